// File: rtl/common_pkg.sv
// Shared scalar aliases and instruction-bus transaction types.
package common_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types shared between the front-end blocks.
package pipes_pkg;
    import common_pkg::*;

    typedef struct packed {
        u64 pc;
        u32 instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FQ_IDLE  = 2'd0,
        FQ_WAIT  = 2'd1,
        FQ_DRAIN = 2'd2
    } fq_state_e;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one bus request at a time into a reserved
// slot of a circular buffer and presents the oldest entry to decode.
//
// state | meaning
// IDLE  | no request outstanding; issue at fetch_pc when a slot is free
// WAIT  | request outstanding; its word will be pushed on data_ok
// DRAIN | request outstanding but flushed; its word is dropped on data_ok
module ifetch_queue
    import common_pkg::*;
    import pipes_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter u64 RESET_PC = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output ibus_req_t                ireq,
    input  ibus_resp_t               iresp,
    input  logic                     redirect_valid,
    input  u64                       redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output u64                       out_pc,
    output u32                       out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_state_e      state;
    fq_state_e      state_nx;
    u64             fetch_pc;
    u64             req_addr;
    u64             bus_addr;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    fetch_entry_t   mem [DEPTH];

    logic           has_room;
    logic           req_valid;
    logic           push;
    logic           pop;
    logic           unused_bits;

    assign unused_bits = ^{iresp.addr_ok, redirect_pc[1:0]};

    // A request only starts with a free slot; one outstanding request at a
    // time means that slot stays reserved until its data arrives.
    assign has_room = (count < CW'(DEPTH));

    always_comb begin
        req_valid = 1'b0;
        if (reset) begin
            if (state == FQ_IDLE) begin
                req_valid = has_room && !redirect_valid;
            end else begin
                req_valid = 1'b1;
            end
        end
    end

    assign bus_addr = (state == FQ_IDLE) ? fetch_pc : req_addr;

    always_comb begin
        ireq       = '0;
        ireq.valid = req_valid;
        ireq.addr  = bus_addr;
    end

    assign push      = req_valid && iresp.data_ok && (state != FQ_DRAIN) && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_valid = (count != '0);
    assign out_pc    = mem[head].pc;
    assign out_instr = mem[head].instr;

    always_comb begin
        state_nx = state;
        case (state)
            FQ_IDLE: begin
                if (req_valid && !iresp.data_ok) begin
                    state_nx = FQ_WAIT;
                end
            end
            FQ_WAIT: begin
                if (iresp.data_ok) begin
                    state_nx = FQ_IDLE;
                end else if (redirect_valid) begin
                    state_nx = FQ_DRAIN;
                end
            end
            FQ_DRAIN: begin
                if (iresp.data_ok) begin
                    state_nx = FQ_IDLE;
                end
            end
            default: state_nx = FQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FQ_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            // Latch the issued address so it holds even if a redirect moves fetch_pc.
            if (state == FQ_IDLE) begin
                req_addr <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[63:2], 2'b00};
            end else if (push) begin
                fetch_pc <= bus_addr + 64'd4;
            end
            if (redirect_valid) begin
                tail  <= head;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: bus_addr, instr: iresp.data};
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a latency-configurable bus model and a
// queue-based reference model are compared against the DUT every cycle.
module tb_ifetch_queue;
    import common_pkg::*;
    import pipes_pkg::*;

    localparam int DEPTH    = 4;
    localparam u64 RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    logic        redirect_valid = 1'b0;
    u64          redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    u64          out_pc;
    u32          out_instr;
    logic [$clog2(DEPTH):0] count;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: what decode should see and what the bus should see.
    fetch_entry_t mq[$];
    u64   m_pc;
    logic m_pend;
    u64   m_paddr;
    logic m_disc;

    // Bus model
    int   fix_lat = 0;
    logic bus_busy;
    int   bus_left;
    int   issued;

    task automatic reset_model();
        mq.delete();
        m_pc     = RESET_PC;
        m_pend   = 1'b0;
        m_paddr  = '0;
        m_disc   = 1'b0;
        bus_busy = 1'b0;
        bus_left = 0;
        issued   = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        iresp          = '0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst count", 64'(count), 64'd0);
        check_eq("rst ireq.valid", 64'(ireq.valid), 64'd0);
        reset_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step(input logic r, input u64 rpc, input logic o);
        logic d;
        logic exp_v;
        u64   exp_a;
        u32   data;
        int   lat;
        @(negedge clk);
        redirect_valid = r;
        redirect_pc    = rpc;
        out_ready      = o;
        #1;
        d    = 1'b0;
        data = $urandom;
        if (bus_busy) begin
            if (bus_left == 0) d = 1'b1;
            else bus_left--;
        end else if (ireq.valid) begin
            issued++;
            lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
                d = 1'b1;
            end else begin
                bus_busy = 1'b1;
                bus_left = lat - 1;
            end
        end
        iresp = '{addr_ok: ireq.valid, data_ok: d, data: data};
        #1;
        exp_v = m_pend || (mq.size() < DEPTH && !r);
        exp_a = m_pend ? m_paddr : m_pc;
        check_eq("ireq.valid", 64'(ireq.valid), 64'(exp_v));
        if (exp_v) check_eq("ireq.addr", ireq.addr, exp_a);
        check_eq("count", 64'(count), 64'(mq.size()));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("out_pc", out_pc, mq[0].pc);
            check_eq("out_instr", 64'(out_instr), 64'(mq[0].instr));
        end
        if (r) begin
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
            if (m_pend) begin
                if (d) begin
                    m_pend = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            if (mq.size() != 0 && o) void'(mq.pop_front());
            if (exp_v && d) begin
                if (!m_disc) begin
                    mq.push_back('{pc: exp_a, instr: data});
                    m_pc = exp_a + 64'd4;
                end
                m_pend = 1'b0;
                m_disc = 1'b0;
            end else if (exp_v) begin
                m_pend  = 1'b1;
                m_paddr = exp_a;
            end
        end
        if (d) bus_busy = 1'b0;
    endtask

    u64 got_pc[$];
    int got_at[$];

    initial begin
        #1 do_reset();

        // Zero-wait bus, decode always ready: back-to-back PCs.
        fix_lat = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            if (out_valid && got_pc.size() < 3) begin
                got_pc.push_back(out_pc);
                got_at.push_back(i);
            end
        end
        check_eq("seq len", 64'(got_pc.size()), 64'd3);
        if (got_pc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check_eq("seq pc", got_pc[k], RESET_PC + 64'(4 * k));
                check_eq("seq cycle", 64'(got_at[k]), 64'(k + 1));
            end
        end

        // Decode stalled: fills exactly DEPTH entries, then one pop frees a slot.
        do_reset();
        fix_lat = 0;
        repeat (8) step(1'b0, '0, 1'b0);
        check_eq("full issued", 64'(issued), 64'd4);
        check_eq("full count", 64'(count), 64'd4);
        check_eq("full ireq.valid", 64'(ireq.valid), 64'd0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check_eq("refill valid", 64'(ireq.valid), 64'd1);
        check_eq("refill addr", ireq.addr, 64'h8000_0010);

        // Redirect one cycle after issue on a 3-cycle bus.
        do_reset();
        fix_lat = 3;
        step(1'b0, '0, 1'b0);
        step(1'b1, 64'h8000_0100, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check_eq("drain count", 64'(count), 64'd0);
        check_eq("drain out_valid", 64'(out_valid), 64'd0);
        check_eq("drain addr", ireq.addr, 64'h8000_0100);

        // Redirect coincident with data_ok and out_ready, unaligned target.
        do_reset();
        fix_lat = 2;
        repeat (5) step(1'b0, '0, 1'b0);
        check_eq("pre-redir count", 64'(count), 64'd1);
        step(1'b1, 64'h8000_0203, 1'b1);
        step(1'b0, '0, 1'b0);
        check_eq("redir count", 64'(count), 64'd0);
        check_eq("redir valid", 64'(ireq.valid), 64'd1);
        check_eq("redir addr", ireq.addr, 64'h8000_0200);

        // Asynchronous reset while a request is outstanding with 3 entries.
        do_reset();
        fix_lat = 0;
        repeat (3) step(1'b0, '0, 1'b0);
        fix_lat = 4;
        step(1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        check_eq("wait count", 64'(count), 64'd3);
        do_reset();
        step(1'b0, '0, 1'b0);
        check_eq("post-rst addr", ireq.addr, RESET_PC);

        // Random traffic.
        do_reset();
        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom},
                 $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-006 SHALL have port iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data[31:0]).
REQ-007 SHALL have port redirect_valid  input  1  flush queue and restart fetch (branch/jump resolved).
REQ-008 SHALL have port redirect_pc  input  64  restart address; bits [1:0] ignored and treated as 0.
REQ-009 SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts head entry this cycle.
REQ-011 SHALL have port out_pc  output  64  PC of head entry.
REQ-012 SHALL have port out_instr  output  32  instruction word of head entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 SHALL hold fetch_pc, a DEPTH-entry circular buffer of {pc, instr}, head/tail pointers, and an FSM with states IDLE, WAIT, DRAIN.
REQ-015 SHALL, in IDLE, assert ireq.valid with ireq.addr = fetch_pc whenever count < DEPTH and redirect_valid = 0, and enter WAIT at the next edge unless data_ok arrives in the same cycle.
REQ-016 SHALL keep ireq.valid = 1 and ireq.addr stable in WAIT and DRAIN until iresp.data_ok = 1; data_ok SHALL be accepted combinationally in the cycle it is asserted.
REQ-017 SHALL, on data_ok in IDLE or WAIT without redirect, push {fetch_pc, iresp.data} at tail, set fetch_pc += 4, and go to IDLE.
REQ-018 SHALL never overflow: a request is issued only when a free slot is reserved for it, so a push always finds space, even when a pop occurs in the same cycle.
REQ-019 SHALL pop the head when out_valid & out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-020 SHALL drive out_valid = (count != 0); out_pc/out_instr SHALL come from registered storage with no bypass, so a pushed word is visible one cycle after data_ok at the earliest.
REQ-021 SHALL, on redirect_valid, clear count, equalise head and tail, set fetch_pc = {redirect_pc[63:2], 2'b00}, and drop any same-cycle push and pop.
REQ-022 SHALL, on redirect while a request is outstanding without same-cycle data_ok, enter DRAIN; in DRAIN, data_ok SHALL be discarded and the FSM SHALL return to IDLE.
REQ-023 SHALL treat redirect in the same cycle as data_ok as discarding that data and going to IDLE.
REQ-024 SHALL treat a redirect during DRAIN as updating fetch_pc only and remaining in DRAIN.
REQ-025 SHALL wrap head and tail modulo DEPTH.

Reset
REQ-026 SHALL, while reset = 0, asynchronously force FSM = IDLE, fetch_pc = RESET_PC, head = tail = 0, count = 0, out_valid = 0, and ireq.valid = 0.
REQ-027 SHALL issue the first request at RESET_PC in the first cycle after reset deasserts.
REQ-028 SHALL treat any in-flight bus transaction as abandoned when reset is asserted mid-operation; the bus model is reset with the core.

Structure
REQ-029 SHALL take ibus_req_t, ibus_resp_t, and u64/u32 from the shared common package; the fetch-entry struct and FSM enum SHALL live in the shared pipes package.
REQ-030 SHALL be a single module with no sub-modules; the storage is an inferred register array.

Verification
REQ-031 Zero-wait bus (data_ok same cycle), out_ready = 1 -> pc 0x8000_0000, 0x8000_0004, 0x8000_0008 appear on consecutive cycles starting cycle 2 after reset.
REQ-032 out_ready = 0, DEPTH = 4 -> exactly 4 requests issued, count = 4, ireq.valid = 0; one pop -> next request at 0x8000_0010.
REQ-033 Bus with 3-cycle data_ok latency, redirect to 0x8000_0100 one cycle after issue -> stale word discarded, count = 0, next request at 0x8000_0100.
REQ-034 Redirect coincident with data_ok and out_ready -> count becomes 0, no entry popped or pushed, next ireq.addr = redirect target.
REQ-035 Redirect to 0x8000_0203 -> ireq.addr = 0x8000_0200.
REQ-036 Reset asserted while in WAIT with count = 3 -> outputs cleared immediately (asynchronously); after release, first request is at RESET_PC.
